// File: rtl/mmu_dport_arb.sv
// Shares the single D-side memory port between the page-table walker (P) and the LSU (L).
// Latency: grant is combinational in IDLE, mem_rd/wr rise the next cycle, response pulses one cycle after mem_rdy_i.
// Backpressure: one transaction in flight; mem_* held stable until mem_rdy_i, no grants outside IDLE.
// Optional macro MMU_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts with resp_err_o = 2'b11.
module mmu_dport_arb #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p_req_i,
  input  logic [31:0] p_addr_i,
  output logic        p_gnt_o,
  output logic        p_resp_valid_o,
  input  logic        l_req_i,
  input  logic        l_wr_i,
  input  logic [31:0] l_addr_i,
  input  logic [31:0] l_data_i,
  input  logic [3:0]  l_mask_i,
  output logic        l_gnt_o,
  output logic        l_resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic [1:0]  resp_err_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_mask_o,
  input  logic        mem_rdy_i,
  input  logic [31:0] mem_data_i,
  input  logic [1:0]  mem_err_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Out-of-range parameters are rejected at elaboration time.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mmu_dport_arb: parameter out of range");
  end

  logic [1:0]  state_q;
  logic [3:0]  starve_cnt_q;
  logic        own_l_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;

  logic idle;
  logic busy;
  logic force_l;
  logic any_gnt;
  logic to_hit;

  assign idle    = (state_q == S_IDLE);
  assign busy    = (state_q == S_BUSY);
  assign force_l = (starve_cnt_q == STARVE_MAX) && l_req_i;

  // Combinational grants; qualified by rst_i so nothing is granted while reset is held.
  assign p_gnt_o = rst_i && idle && p_req_i && !force_l;
  assign l_gnt_o = rst_i && idle && l_req_i && (!p_req_i || force_l);
  assign any_gnt = p_gnt_o || l_gnt_o;

  // Downstream strobes decode straight from state so an async reset drops them at once.
  assign mem_rd_o       = busy && !wr_q;
  assign mem_wr_o       = busy && wr_q;
  assign mem_addr_o     = addr_q;
  assign mem_data_o     = data_q;
  assign mem_mask_o     = mask_q;
  assign p_resp_valid_o = (state_q == S_RESP) && !own_l_q;
  assign l_resp_valid_o = (state_q == S_RESP) && own_l_q;

`ifdef MMU_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  assign to_hit = busy && !mem_rdy_i && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts on every grant, counts BUSY cycles that saw no completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 to_cnt_q <= 16'd0;
    else if (any_gnt)           to_cnt_q <= 16'd0;
    else if (busy && !mem_rdy_i) to_cnt_q <= to_cnt_q + 16'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Starvation guard: counts P wins while L waits, cleared when L wins or stops asking.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_q <= 4'd0;
    end else if (idle) begin
      if (l_gnt_o || !l_req_i)
        starve_cnt_q <= 4'd0;
      else if (p_gnt_o && starve_cnt_q != STARVE_MAX)
        starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end

  // Main FSM: latch the granted request, wait for completion, emit one response cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      own_l_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      mask_q      <= 4'd0;
      resp_data_o <= 32'd0;
      resp_err_o  <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_gnt) begin
            state_q <= S_BUSY;
            own_l_q <= l_gnt_o;
            if (l_gnt_o) begin
              addr_q <= l_addr_i;
              wr_q   <= l_wr_i;
              data_q <= l_data_i;
              mask_q <= l_wr_i ? l_mask_i : 4'hF;
            end else begin
              addr_q <= p_addr_i;
              wr_q   <= 1'b0;
              data_q <= 32'd0;
              mask_q <= 4'hF;
            end
          end
        end
        S_BUSY: begin
          // A completion in the same cycle as the watchdog expiry takes precedence.
          if (mem_rdy_i) begin
            resp_data_o <= mem_data_i;
            resp_err_o  <= mem_err_i;
            state_q     <= S_RESP;
          end else if (to_hit) begin
            resp_data_o <= 32'd0;
            resp_err_o  <= 2'b11;
            state_q     <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_dport_arb.sv
module tb_mmu_dport_arb;

  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        p_req_i, l_req_i, l_wr_i, mem_rdy_i;
  logic [31:0] p_addr_i, l_addr_i, l_data_i, mem_data_i;
  logic [3:0]  l_mask_i;
  logic [1:0]  mem_err_i;
  logic        p_gnt_o, p_resp_valid_o, l_gnt_o, l_resp_valid_o;
  logic [31:0] resp_data_o, mem_addr_o, mem_data_o;
  logic [1:0]  resp_err_o;
  logic        mem_rd_o, mem_wr_o;
  logic [3:0]  mem_mask_o;

  int n_assert = 0;
  int n_fail   = 0;

  mmu_dport_arb #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p_req_i(p_req_i), .p_addr_i(p_addr_i), .p_gnt_o(p_gnt_o), .p_resp_valid_o(p_resp_valid_o),
    .l_req_i(l_req_i), .l_wr_i(l_wr_i), .l_addr_i(l_addr_i), .l_data_i(l_data_i),
    .l_mask_i(l_mask_i), .l_gnt_o(l_gnt_o), .l_resp_valid_o(l_resp_valid_o),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o),
    .mem_rdy_i(mem_rdy_i), .mem_data_i(mem_data_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one transaction slot described as "in flight" / "answering".
  bit          m_inflight, m_answer, m_owner_l, m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_mask;
  logic [1:0]  m_rerr;
  int          m_starve, m_wait;

  task automatic model_reset();
    m_inflight = 0; m_answer = 0; m_owner_l = 0; m_write = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_mask = 0; m_rerr = 0;
    m_starve = 0; m_wait = 0;
  endtask

  function automatic bit m_idle();
    return !m_inflight && !m_answer;
  endfunction

  function automatic bit m_pwin();
    bit forced;
    forced = m_idle() && (m_starve == SL) && l_req_i;
    return m_idle() && p_req_i && !forced;
  endfunction

  function automatic bit m_lwin();
    return m_idle() && l_req_i && !m_pwin();
  endfunction

  // Advance the model using the inputs the DUT is about to sample.
  task automatic model_step();
    bit pw, lw;
    pw = m_pwin(); lw = m_lwin();
    if (m_answer) begin
      m_answer = 0;
    end else if (m_inflight) begin
      if (mem_rdy_i) begin
        m_rdata = mem_data_i; m_rerr = mem_err_i; m_inflight = 0; m_answer = 1;
      end
`ifdef MMU_ARB_TIMEOUT_EN
      else if (m_wait == TO - 1) begin
        m_rdata = 0; m_rerr = 2'b11; m_inflight = 0; m_answer = 1;
      end
`endif
      else m_wait++;
    end else begin
      if (pw || lw) begin
        m_inflight = 1; m_owner_l = lw; m_wait = 0;
        m_write = lw && l_wr_i;
        m_addr  = lw ? l_addr_i : p_addr_i;
        m_wdata = lw ? l_data_i : 32'd0;
        m_mask  = m_write ? l_mask_i : 4'hF;
      end
      if (lw || !l_req_i) m_starve = 0;
      else if (pw)        m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("m_pgnt", p_gnt_o, m_pwin());
    chk("m_lgnt", l_gnt_o, m_lwin());
    chk("m_rd", mem_rd_o, m_inflight && !m_write);
    chk("m_wr", mem_wr_o, m_inflight && m_write);
    chk("m_presp", p_resp_valid_o, m_answer && !m_owner_l);
    chk("m_lresp", l_resp_valid_o, m_answer && m_owner_l);
    chk("m_rdata", resp_data_o, m_rdata);
    chk("m_rerr", resp_err_o, m_rerr);
    if (m_inflight) begin
      chk("m_addr", mem_addr_o, m_addr);
      chk("m_mask", mem_mask_o, m_mask);
      if (m_write) chk("m_wdata", mem_data_o, m_wdata);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_i = 0; p_req_i = 0; l_req_i = 0; l_wr_i = 0; mem_rdy_i = 0;
    p_addr_i = 0; l_addr_i = 0; l_data_i = 0; mem_data_i = 0; l_mask_i = 0; mem_err_i = 0;
    model_reset();

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(posedge clk_i);
    #1; p_req_i = 1; l_req_i = 1; settle();
    chk("rst_pgnt", p_gnt_o, 0);
    chk("rst_lgnt", l_gnt_o, 0);
    chk("rst_rd", mem_rd_o, 0);
    chk("rst_rdata", resp_data_o, 0);
    p_req_i = 0; l_req_i = 0;
    @(posedge clk_i); #1; rst_i = 1;

    // Basic PTW read with 3-cycle downstream wait.
    p_req_i = 1; p_addr_i = 32'h8000_1000; settle();
    chk("t1_pgnt", p_gnt_o, 1);
    chk("t1_lgnt", l_gnt_o, 0);
    tick(); p_req_i = 0; settle();
    chk("t1_rd", mem_rd_o, 1);
    chk("t1_wr", mem_wr_o, 0);
    chk("t1_addr", mem_addr_o, 32'h8000_1000);
    chk("t1_mask", mem_mask_o, 4'hF);
    tick(); settle(); chk("t1_rd_hold", mem_rd_o, 1);
    tick(); mem_rdy_i = 1; mem_data_i = 32'hCAFE_F00D; mem_err_i = 0;
    tick(); mem_rdy_i = 0; settle();
    chk("t1_presp", p_resp_valid_o, 1);
    chk("t1_lresp", l_resp_valid_o, 0);
    chk("t1_data", resp_data_o, 32'hCAFE_F00D);
    chk("t1_err", resp_err_o, 0);
    chk("t1_rd_drop", mem_rd_o, 0);
    tick(); settle(); chk("t1_presp_end", p_resp_valid_o, 0);

    // Simultaneous requests: P first, L in the IDLE after P's response.
    p_req_i = 1; p_addr_i = 32'h40; l_req_i = 1; l_wr_i = 1;
    l_addr_i = 32'h2000_0010; l_mask_i = 4'b0011; l_data_i = 32'h1234_5678; settle();
    chk("t2_pgnt", p_gnt_o, 1);
    chk("t2_lgnt0", l_gnt_o, 0);
    tick(); p_req_i = 0; mem_rdy_i = 1; mem_data_i = 32'h1111_1111; mem_err_i = 2'b01; settle();
    chk("t2_prd", mem_rd_o, 1);
    tick(); mem_rdy_i = 0; settle();
    chk("t2_presp", p_resp_valid_o, 1);
    chk("t2_perr", resp_err_o, 2'b01);
    chk("t2_no_gnt_resp", l_gnt_o, 0);
    tick(); settle();
    chk("t2_lgnt", l_gnt_o, 1);
    tick(); l_req_i = 0; settle();
    chk("t2_wr", mem_wr_o, 1);
    chk("t2_rd", mem_rd_o, 0);
    chk("t2_mask", mem_mask_o, 4'b0011);
    chk("t2_wdata", mem_data_o, 32'h1234_5678);
    chk("t2_addr", mem_addr_o, 32'h2000_0010);
    mem_rdy_i = 1; mem_data_i = 32'hDEAD_BEEF; mem_err_i = 0;
    tick(); mem_rdy_i = 0; settle();
    chk("t2_lresp", l_resp_valid_o, 1);
    chk("t2_presp_l", p_resp_valid_o, 0);
    chk("t2_ldata", resp_data_o, 32'hDEAD_BEEF);
    tick();

    // Starvation guard: P P P P L, repeating.
    p_req_i = 1; l_req_i = 1; l_wr_i = 0; mem_rdy_i = 1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t3_pgnt", p_gnt_o, (i % 5) != 4);
      chk("t3_lgnt", l_gnt_o, (i % 5) == 4);
      tick(); tick(); tick();
    end
    p_req_i = 0; l_req_i = 0; mem_rdy_i = 0;

    // Zero-wait completion: 3-cycle turnaround, one mem_rd cycle each.
    p_req_i = 1; mem_rdy_i = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_gnt", p_gnt_o, 1); chk("t4_rd0", mem_rd_o, 0);
      tick(); settle();
      chk("t4_rd1", mem_rd_o, 1); chk("t4_gnt1", p_gnt_o, 0); chk("t4_resp1", p_resp_valid_o, 0);
      tick(); settle();
      chk("t4_resp2", p_resp_valid_o, 1); chk("t4_rd2", mem_rd_o, 0); chk("t4_gnt2", p_gnt_o, 0);
      tick();
    end
    p_req_i = 0; mem_rdy_i = 0;

    // Reset mid-transaction.
    p_req_i = 1; p_addr_i = 32'hA0; settle();
    chk("t5_pgnt", p_gnt_o, 1);
    tick(); p_req_i = 0; settle();
    chk("t5_rd", mem_rd_o, 1);
    rst_i = 0; #1;
    chk("t5_rd_async", mem_rd_o, 0);
    chk("t5_presp", p_resp_valid_o, 0);
    mem_rdy_i = 1;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1; mem_rdy_i = 0; model_reset(); settle();
    chk("t5_noresp_p", p_resp_valid_o, 0);
    chk("t5_noresp_l", l_resp_valid_o, 0);
    tick(); settle(); chk("t5_noresp2", p_resp_valid_o, 0);
    p_req_i = 1; p_addr_i = 32'hB0; settle();
    chk("t5_regnt", p_gnt_o, 1);
    tick(); p_req_i = 0; mem_rdy_i = 1; mem_data_i = 32'h5; settle();
    chk("t5_addr", mem_addr_o, 32'hB0);
    tick(); mem_rdy_i = 0; settle();
    chk("t5_resp", p_resp_valid_o, 1);
    chk("t5_data", resp_data_o, 32'h5);
    tick();

`ifdef MMU_ARB_TIMEOUT_EN
    // Watchdog expiry, then rdy coinciding with the expiry cycle.
    p_req_i = 1; p_addr_i = 32'hC0; settle(); tick(); p_req_i = 0;
    for (int i = 0; i < TO; i++) begin settle(); chk("to_rd_hold", mem_rd_o, 1); tick(); end
    settle();
    chk("to_rd_drop", mem_rd_o, 0);
    chk("to_resp", p_resp_valid_o, 1);
    chk("to_err", resp_err_o, 2'b11);
    chk("to_data", resp_data_o, 0);
    tick();
    p_req_i = 1; settle(); tick(); p_req_i = 0;
    repeat (TO - 1) tick();
    mem_rdy_i = 1; mem_data_i = 32'h77; mem_err_i = 0; tick(); mem_rdy_i = 0; settle();
    chk("to_race_resp", p_resp_valid_o, 1);
    chk("to_race_err", resp_err_o, 0);
    chk("to_race_data", resp_data_o, 32'h77);
    tick();
`endif

    // Randomised traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      p_req_i    = ($urandom_range(0, 2) != 0);
      l_req_i    = ($urandom_range(0, 2) != 0);
      l_wr_i     = $urandom_range(0, 1);
      p_addr_i   = $urandom;
      l_addr_i   = $urandom;
      l_data_i   = $urandom;
      l_mask_i   = 4'($urandom_range(0, 15));
      mem_rdy_i  = ($urandom_range(0, 2) == 0);
      mem_data_i = $urandom;
      mem_err_i  = 2'($urandom_range(0, 3));
      settle();
      chk_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
